// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// status bit layout and TX state encodings.
package mmio_uart_tx_pkg;

    localparam logic [31:0] DEF_TXD_ADDR  = 32'h4000_0018;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h4000_0020;

    // Status word bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;  // count occupies [7:4]

    // TX state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Word-address compare: byte offset bits are ignored
    function automatic logic wordMatch(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:2] == base[31:2];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small circular byte FIFO feeding the UART shifter. Pushes when full and
// pops when empty are ignored; the head entry is presented combinationally.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic          doPush, doPop;

    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = count == '0;
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr];

    // Storage, pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MEM-stage mapped UART transmitter: register decode, status readback,
// sticky overflow flag and the 8N1 serialiser.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TXD_ADDR     = DEF_TXD_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic          txdHit, statHit;
    logic          overflow;
    logic [1:0]    state;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          txReg;
    logic          baudDone;
    logic          fifoPop, fifoFull, fifoEmpty;
    logic [7:0]    fifoDout;
    logic [AW:0]   fifoCount;
    logic          unusedBits;

    assign unusedBits = &{1'b0, WriteData[31:8]};

    assign txdHit  = wordMatch(Address, TXD_ADDR);
    assign statHit = wordMatch(Address, STAT_ADDR);
    assign hit     = txdHit || statHit;

    assign baudDone = baudCnt == CW'(CLKS_PER_BIT - 1);
    // Pop from IDLE, or at the end of STOP so frames run back-to-back
    assign fifoPop  = !fifoEmpty &&
                      ((state == ST_IDLE) || (state == ST_STOP && baudDone));
    assign tx = txReg;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .clk   (clk),
        .reset (reset),
        .push  (MemWrite && txdHit),
        .din   (WriteData[7:0]),
        .pop   (fifoPop),
        .dout  (fifoDout),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Same-cycle status readback; anything other than a status load reads 0
    always_comb begin
        ReadData = '0;
        if (MemRead && statHit) begin
            ReadData[STAT_BUSY]            = state != ST_IDLE;
            ReadData[STAT_FULL]            = fifoFull;
            ReadData[STAT_EMPTY]           = fifoEmpty;
            ReadData[STAT_OVF]             = overflow;
            ReadData[STAT_CNT+3:STAT_CNT]  = 4'(fifoCount);
        end
    end

    // Sticky overflow: set by a store that finds the FIFO full, cleared by a status store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            overflow <= 1'b0;
        else if (MemWrite && txdHit && fifoFull) overflow <= 1'b1;
        else if (MemWrite && statHit)          overflow <= 1'b0;
    end

    // Frame sequencer; tx is loaded with the level of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    txReg <= 1'b1;
                    if (!fifoEmpty) begin
                        shiftReg <= fifoDout;
                        state    <= ST_START;
                        baudCnt  <= '0;
                        txReg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        state   <= ST_DATA;
                        txReg   <= shiftReg[0];
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state <= ST_STOP;
                            txReg <= 1'b1;
                        end else begin
                            shiftReg <= shiftReg >> 1;
                            bitIdx   <= bitIdx + 1'b1;
                            txReg    <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
                default: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (!fifoEmpty) begin
                            shiftReg <= fifoDout;
                            state    <= ST_START;
                            txReg    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            txReg <= 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: stores feed an expected-byte queue, a line monitor
// decodes frames off tx and checks them against that queue.
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] TXD  = 32'h4000_0018;
    localparam logic [31:0] STAT = 32'h4000_0020;

    logic        clk = 0, reset = 0;
    logic [31:0] Address = 0, WriteData = 0;
    logic        MemRead = 0, MemWrite = 0;
    logic [31:0] ReadData;
    logic        hit, tx;

    int total = 0, bad = 0;
    int cyc = 0;
    bit sbOn = 1;
    logic [7:0] expQ[$];
    int startTimes[$];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
        .hit(hit), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; store is taken at the following posedge, returns at next negedge
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1;
        @(negedge clk);
        MemWrite = 0;
    endtask

    task automatic readStat(output logic [31:0] v);
        Address = STAT; MemRead = 1;
        #1 v = ReadData;
        MemRead = 0;
    endtask

    // Expected status word from abstract quantities
    function automatic logic [31:0] mkStat(input int cnt, input bit busy, input bit ovf);
        return (cnt << 4) | (ovf << 3) | ((cnt == 0) << 2) | ((cnt == DEPTH) << 1) | busy;
    endfunction

    // Poll busy at negedges; returns cycles until idle, or -1 on budget expiry
    task automatic waitIdle(input int budget, output int n);
        logic [31:0] s;
        n = 0;
        readStat(s);
        while (s[0]) begin
            @(negedge clk);
            n++;
            if (n > budget) begin n = -1; return; end
            readStat(s);
        end
    endtask

    // Line monitor: detect start bit, sample each bit at its middle
    initial begin
        logic [7:0] b;
        logic sb, pb;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                startTimes.push_back(cyc);
                repeat (2) @(negedge clk);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                pb = tx;
                if (sbOn) begin
                    chk("startBit", {31'b0, sb}, 32'h0);
                    chk("stopBit", {31'b0, pb}, 32'h1);
                    if (expQ.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpectedFrame: got %h expected none", b);
                    end else begin
                        e = expQ.pop_front();
                        chk("frameByte", {24'b0, b}, {24'b0, e});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] s;
        int n, t0, lowCnt;
        logic [7:0] v [5];
        logic [7:0] r;

        // Reset state
        repeat (3) @(negedge clk);
        readStat(s);
        chk("statInReset", s, 32'h4);
        chk("txInReset", {31'b0, tx}, 32'h1);
        reset = 1;
        @(negedge clk);
        readStat(s);
        chk("statAfterReset", s, 32'h4);
        chk("hitStat", {31'b0, hit}, 32'h1);
        chk("txIdle", {31'b0, tx}, 32'h1);
        Address = STAT | 32'h3; MemRead = 1;
        #1 chk("statByteOffset", ReadData, 32'h4);
        Address = 32'h4000_0000;
        #1 chk("missHit", {31'b0, hit}, 32'h0);
        chk("missData", ReadData, 32'h0);
        Address = TXD;
        #1 chk("txdReadHit", {31'b0, hit}, 32'h1);
        chk("txdReadData", ReadData, 32'h0);
        MemRead = 0;
        @(negedge clk);

        // Single frame 0x55, latency and length
        expQ.push_back(8'h55);
        store(TXD, 32'hDEAD_BE55);
        chk("noBypassTx", {31'b0, tx}, 32'h1);
        readStat(s);
        chk("statQueued", s, mkStat(1, 0, 0));
        @(negedge clk);
        chk("startFall", {31'b0, tx}, 32'h0);
        readStat(s);
        chk("statSending", s, mkStat(0, 1, 0));
        waitIdle(2000, n);
        chk("frameLen", n, 40);

        // Fill, overflow, clear
        for (int i = 1; i <= 5; i++) begin
            expQ.push_back(8'(i));
            store(TXD, 32'(i));
        end
        readStat(s);
        chk("statFull", s, mkStat(DEPTH, 1, 0));
        store(TXD, 32'h06);
        readStat(s);
        chk("statOvf", s, mkStat(DEPTH, 1, 1));
        store(STAT, 32'hFFFF_FFFF);
        readStat(s);
        chk("statOvfClr", s, mkStat(DEPTH, 1, 0));
        waitIdle(2000, n);
        chk("fillDrained", {31'b0, n < 0}, 32'h0);
        readStat(s);
        chk("statIdle1", s, 32'h4);

        // Back-to-back frames
        startTimes.delete();
        expQ.push_back(8'hA5); expQ.push_back(8'h3C);
        store(TXD, 32'hA5);
        store(TXD, 32'h3C);
        waitIdle(2000, n);
        chk("b2bTotal", n, 80);
        chk("b2bFrames", startTimes.size(), 2);
        if (startTimes.size() == 2)
            chk("b2bGap", startTimes[1] - startTimes[0], 40);

        // Store while full in the same cycle the STOP state pops
        for (int i = 0; i < 5; i++) v[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) expQ.push_back(v[i]);
        store(TXD, {24'b0, v[0]});
        for (int i = 1; i < 5; i++) store(TXD, {24'b0, v[i]});
        repeat (36) @(negedge clk);
        readStat(s);
        chk("statFullPrePop", s, mkStat(DEPTH, 1, 0));
        store(TXD, 32'h77);
        readStat(s);
        chk("statPopDrop", s, mkStat(DEPTH - 1, 1, 1));
        store(STAT, 32'h0);
        waitIdle(4000, n);
        chk("popDropDrained", {31'b0, n < 0}, 32'h0);

        // Randomized traffic with flow control from the full bit
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            n = 0;
            readStat(s);
            while (s[1] && n < 1000) begin @(negedge clk); n++; readStat(s); end
            r = 8'($urandom);
            expQ.push_back(r);
            store(TXD | 32'($urandom_range(0, 3)), {24'($urandom), r});
        end
        waitIdle(8000, n);
        chk("randDrained", {31'b0, n < 0}, 32'h0);
        repeat (5) @(negedge clk);
        chk("expQEmpty", expQ.size(), 0);

        // Reset mid-DATA of 0xFF with two bytes queued
        sbOn = 0;
        store(TXD, 32'hFF);
        store(TXD, 32'h00);
        store(TXD, 32'h00);
        repeat (12) @(negedge clk);
        readStat(s);
        chk("statPreReset", s, mkStat(2, 1, 0));
        reset = 0;
        #1 chk("txOnReset", {31'b0, tx}, 32'h1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        readStat(s);
        chk("statPostReset", s, 32'h4);
        lowCnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lowCnt++;
        end
        chk("noFramePostReset", lowCnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the pipeline's MEM-stage data bus, alongside the data memory.
- Consumes the MEM-stage address, write data and memory control strobes.
- Buffers bytes written by the program in a small FIFO and serialises them 8N1 on a TX pin.
- Returns a status word on reads so software can poll before writing.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values ≥ 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..8.
- TXD_ADDR, 32'h4000_0018, word address of the transmit-data register.
- STAT_ADDR, 32'h4000_0020, word address of the status register.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state.
- Address  input  32  MEM-stage ALU result (byte address).
- WriteData  input  32  MEM-stage store data.
- MemRead  input  1  MEM-stage load strobe.
- MemWrite  input  1  MEM-stage store strobe.
- ReadData  output  32  status word when selected, else 0.
- hit  output  1  Address matches TXD_ADDR or STAT_ADDR; top level uses it to mux ReadData.
- tx  output  1  serial line, idles high.

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0, tx=1.
- ReadData and hit are combinational: same-cycle load data, matching the data memory's read timing.
- Address decode:
  - Compare Address[31:2] against the parameter word address; ignore bits [1:0].
  - Other addresses: no effect; ReadData=0.
- Push:
  - Occurs on MemWrite && TXD hit at the clk edge; WriteData[7:0] is enqueued.
  - If count==FIFO_DEPTH before the edge, the byte is dropped and overflow is set (sticky). This holds even when the FSM pops in the same cycle.
- Clear overflow: MemWrite && STAT hit clears overflow. Data is ignored and the FIFO is untouched.
- Status read (MemRead && STAT hit), unused bits read 0:
  - bit0 busy: FSM != IDLE.
  - bit1 full: count==FIFO_DEPTH.
  - bit2 empty: count==0.
  - bit3 overflow.
  - bits[7:4] count.
- MemRead on TXD_ADDR returns 0 and has no side effect.
- FIFO:
  - Circular buffer with rd/wr pointers of width log2(FIFO_DEPTH); pointers wrap modulo depth.
  - count has width log2(FIFO_DEPTH)+1.
  - Simultaneous push (not full) and pop: count unchanged, both pointers advance.
- TX FSM, one baud counter counting 0..CLKS_PER_BIT-1:
  - IDLE: tx=1. If count>0, pop the head into shift register, go to START, clear counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. LSB first. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: store at edge N → count=1 after N → FSM enters START at edge N+1 → tx falls after edge N+1.
- Push into an empty FIFO is not visible to the FSM until the next cycle; there is no bypass.
- tx is registered, so there are no glitches.
- Reset asserted mid-frame: tx returns to 1 immediately (async); queued bytes are lost.

Decomposition:
- Shared package/header: TXD_ADDR, STAT_ADDR, status bit positions, FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3).
- One sub-module: uart_tx_fifo.
  - Parameter DEPTH.
  - Ports: clk, reset, push, din[7:0], pop, dout[7:0], count, full, empty.
  - dout is combinational from the head entry.
- Top: address decode, status mux, overflow flag, FSM/baud/shift logic.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then read STAT_ADDR → ReadData=32'h4 (empty), tx=1, hit=1; read 32'h4000_0000 → hit=0, ReadData=0.
- Store 32'hXXXX_XX55 to TXD_ADDR → tx=0 for 4 cycles starting one cycle after the store edge; bits 1,0,1,0,1,0,1,0 at 4 cycles each; stop high 4 cycles; busy=0 after 40 cycles.
- Five stores of 8'h01..8'h05 on consecutive cycles → first is popped; final count=4, overflow=0. Sixth store while full → dropped, status bit3=1. Store to STAT_ADDR → bit3=0.
- Queue 8'hA5, 8'h3C → two frames back-to-back: the second start bit begins on the cycle after the first stop bit ends; total 80 cycles; tx never idles between frames.
- Store while FIFO full and FSM popping in the same cycle → byte dropped, overflow=1, count=FIFO_DEPTH-1 afterwards.
- Assert reset=0 mid-DATA of frame 8'hFF with 2 bytes queued → tx=1 immediately; after release status=32'h4, no further frames.
